// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier (mul_seq).
// Optional two's-complement mode is enabled with MUL_SIGNED_EN.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_MIN = 2;
  localparam int W_MAX = 32;

  function automatic bit w_legal(input int w);
    return (w >= W_MIN) && (w <= W_MAX);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration on the (2W+1)-bit accumulator {hi[W:0], lo[W-1:0]}.
// With MUL_SIGNED_EN the multiplicand is sign-extended and the last step may subtract.
module mul_step #(
  parameter int W = 8
) (
  input  logic [2*W:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         mbit,
`ifdef MUL_SIGNED_EN
  input  logic         sub,
  input  logic         sgn,
`endif
  output logic [2*W:0] nxt
);

  logic [W:0] hi;
  logic [W:0] addend;
  logic [W:0] sum;
  logic       fill;

  always_comb begin
    hi     = acc[2*W:W];
    addend = {1'b0, mcand};
    fill   = 1'b0;
`ifdef MUL_SIGNED_EN
    if (sgn) addend = {mcand[W-1], mcand};
    sum = hi;
    if (mbit) sum = sub ? (hi - addend) : (hi + addend);
    // signed partial products shift arithmetically; unsigned carry shifts in a zero
    if (sgn) fill = sum[W];
`else
    sum = mbit ? (hi + addend) : hi;
`endif
    nxt = (2*W+1)'({fill, sum, acc[W-1:0]} >> 1);
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential W-bit shift-add multiplier, one multiplier bit per clock, start/fin handshake.
// Define MUL_SIGNED_EN to add the sgn port and two's-complement products.
module mul_seq
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           ck,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic           sgn,
`endif
  output logic [2*W-1:0] o,
  output logic           fin,
  output logic           busy
);

  localparam int CW = $clog2(W);

  generate
    if (!w_legal(W)) begin : g_w_check
      $error("mul_seq: W=%0d outside legal range", W);
    end
  endgenerate

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W:0]  acc, acc_n;
  logic [W-1:0]  mcand;
  logic          take;
  logic          last;
`ifdef MUL_SIGNED_EN
  logic          sgn_q;
`endif

  always_ff @(posedge ck) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          take    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(W-1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        if (start) begin
          take    = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  mul_step #(.W(W)) u_step (
    .acc   (acc),
    .mcand (mcand),
    .mbit  (acc[0]),
`ifdef MUL_SIGNED_EN
    .sub   (sgn_q & last),
    .sgn   (sgn_q),
`endif
    .nxt   (acc_n)
  );

  // operand capture / iteration / result stage
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      o     <= '0;
      fin   <= 1'b0;
`ifdef MUL_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else begin
      fin <= last;
      if (take) begin
        mcand <= a;
        acc   <= {{(W+1){1'b0}}, b};
        cnt   <= '0;
`ifdef MUL_SIGNED_EN
        sgn_q <= sgn;
`endif
      end else if (state == RUN) begin
        acc <= acc_n;
        cnt <= cnt + CW'(1);
      end
      if (last) o <= acc_n[2*W-1:0];
    end
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential shift-add multiplier with a start/fin handshake, one multiplier bit retired per clock. It generalises the fixed 8-bit multi-cycle multiplier to any operand width W. It adds an optional two's-complement mode, a `busy` flag and back-to-back operation. It sits beside the arithmetic datapath as a low-area multiplier and is driven by a simple controller or a bench.

## Interface
- `W`, default 8: operand width; legal range 2..32.
- `ck` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low; one clock, synchronous, active-low reset.
- `start` in 1: request; sampled on the rising edge when the block can accept.
- `a` in W: multiplicand; captured with an accepted `start`.
- `b` in W: multiplier; captured with an accepted `start`.
- `sgn` in 1: 1 = operands are two's complement. Present only with `MUL_SIGNED_EN`.
- `o` out 2W: product; holds the last result until the next `fin`.
- `fin` out 1: one-cycle pulse; `o` is valid and new while high.
- `busy` out 1: high while an operation is in progress (RUN state).

## Operation
- State machine in `mul_pkg::state_t`:
  - IDLE: `start` = 1 captures `a`, `b` and `sgn`, clears the accumulator, sets `cnt` = 0, goes to RUN.
  - RUN: each cycle, if multiplier bit 0 = 1, add the multiplicand into the upper half of the accumulator, then shift right by 1. `cnt` increments each cycle. At `cnt` = W-1 the state goes to DONE and the final value is loaded into `o`.
  - DONE: `fin` = 1. If `start` = 1, capture new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Accumulator is 2W+1 bits, so the carry out of the add is never lost.
- `o` is the low 2W bits of the accumulator, exact for unsigned operands: max (2^W-1)^2 fits in 2W bits.
- `start` in RUN is ignored; there is no queueing. The operands captured at acceptance are used, so later changes to `a`/`b` have no effect.
- `fin` is registered and is never asserted for two consecutive cycles without a new accepted `start`.
- Reset: `o` = 0, `fin` = 0, `busy` = 0, state IDLE, `cnt` = 0, accumulator = 0. Reset asserted mid-operation aborts the operation; no `fin` is produced for it.

## Timing
- `start` accepted at edge 0. RUN occupies edges 1..W. Edge W loads `o` and raises `fin`; edge W+1 lowers `fin`.
- Latency: W cycles from the accepting edge to `fin` high. With `start` held high in DONE, throughput is one result every W+1 cycles.
- `busy` is high from edge 0+ through edge W; it is low in IDLE and DONE.
- Operands are sampled at edge 0 only.

## Configuration
- `MUL_SIGNED_EN` defined:
  - `sgn` port exists.
  - With `sgn` = 1, the accumulator add sign-extends the multiplicand, and the final iteration (multiplier MSB) subtracts instead of adds.
  - `o` is then the 2W-bit two's-complement product.
  - With `sgn` = 0, behaviour is identical to unsigned.
- `MUL_SIGNED_EN` undefined: no `sgn` port, unsigned only, no subtract path.

## Structure
- Package `mul_pkg`: `state_t` (IDLE, RUN, DONE) and the `W` legal-range check.
- One sub-module `mul_step`: combinational add/subtract-and-shift of the (2W+1)-bit accumulator. Inputs are the accumulator, the multiplicand, the current multiplier bit and a subtract flag. Output is the next accumulator.
- Counter, state register and output registers stay in `mul_seq`.

## Test plan
- W=8, exhaustive unsigned `a`,`b` in 0..255, `start` re-asserted in DONE. Required:
  - `o` == `a*b` at every `fin`, e.g. 0xFF*0xFF -> 0xFE01.
  - `fin` exactly 8 cycles after acceptance.
- W=16: 0xFFFF*0xFFFF -> `o` = 0xFFFE0001 with 16-cycle latency; 0x0000*0x1234 -> 0x00000000.
- Signed (`MUL_SIGNED_EN`, W=8, `sgn` = 1):
  - 0x80*0x80 -> 0x4000.
  - 0xFF*0x01 -> 0xFFFF.
  - 0x7F*0x80 -> 0xC080.
- `start` pulsed with 0x03*0x05 at cycle 3 of an active 0x10*0x10 operation -> ignored. Required: single `fin` with `o` = 0x0100, `busy` never drops early.
- `rst_n` low for one edge at cycle 4 of 0x12*0x34. Required:
  - `o` = 0, `fin` = 0, `busy` = 0 the next cycle, and no `fin` for the aborted operation.
  - A following 0x12*0x34 gives 0x03A8.
- Operands changed while `busy` = 1 (0x0A*0x0B accepted, then inputs set to 0xFF) -> `o` = 0x006E.
